// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// FSM state codes, ALU operation codes and aluop classes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_ZERO = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ZERO  = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from aluop class and R-type funct field.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_ZERO;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alucontrol = ALU_ADD;
          FN_SUB:  o_alucontrol = ALU_SUB;
          FN_AND:  o_alucontrol = ALU_AND;
          FN_OR:   o_alucontrol = ALU_OR;
          FN_SLT:  o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_ZERO;
        endcase
      end
      default: o_alucontrol = ALU_ZERO;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle MIPS datapath; enables are gated off
// combinationally while reset_n is low so no partial write can complete.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_memwrite;
  logic [1:0] w_aluop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_aluop    = ALUOP_ADD;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        alusrcb   = 2'b01;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_aluop      (w_aluop),
    .i_funct      (funct),
    .o_alucontrol (alucontrol)
  );

  // reset_n gating makes enables drop the instant reset asserts, not at the next edge
  assign pcen     = reset_n & (w_pcwrite | (w_branch & zero));
  assign irwrite  = reset_n & w_irwrite;
  assign regwrite = reset_n & w_regwrite;
  assign memwrite = reset_n & w_memwrite;
  assign state    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller, plus reset corner sequences.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic [14:0] ctl;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state      (state)
  );

  always #5 clk = ~clk;

  // {pcen,irwrite,regwrite,memwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol}
  assign ctl = {pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol};

  localparam logic [14:0] C_RST    = 15'b0_0_0_0_0_0_0_0_01_00_010;
  localparam logic [14:0] C_FETCH  = 15'b1_1_0_0_0_0_0_0_01_00_010;
  localparam logic [14:0] C_DECODE = 15'b0_0_0_0_0_0_0_0_11_00_010;
  localparam logic [14:0] C_MEMADR = 15'b0_0_0_0_0_0_0_1_10_00_010;
  localparam logic [14:0] C_MEMRD  = 15'b0_0_0_0_1_0_0_0_00_00_010;
  localparam logic [14:0] C_MEMWB  = 15'b0_0_1_0_0_1_0_0_00_00_010;
  localparam logic [14:0] C_MEMWR  = 15'b0_0_0_1_1_0_0_0_00_00_010;
  localparam logic [14:0] C_ALUWB  = 15'b0_0_1_0_0_0_1_0_00_00_010;
  localparam logic [14:0] C_BEQ_T  = 15'b1_0_0_0_0_0_0_1_00_01_110;
  localparam logic [14:0] C_BEQ_F  = 15'b0_0_0_0_0_0_0_1_00_01_110;
  localparam logic [14:0] C_ADDIWB = 15'b0_0_1_0_0_0_0_0_00_00_010;
  localparam logic [14:0] C_JUMP   = 15'b1_0_0_0_0_0_0_0_00_10_010;
  localparam logic [11:0] C_EXEC   = 12'b0_0_0_0_0_0_0_1_00_00;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  st;
    logic [14:0] ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic [3:0] s, input logic [14:0] c);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.st = s; v.ctl = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic add_rtype(input logic [5:0] f, input logic [2:0] alu);
    add(6'b000000, f, 1'b0, 4'd0, C_FETCH);
    add(6'b000000, f, 1'b0, 4'd1, C_DECODE);
    add(6'b000000, f, 1'b0, 4'd6, {C_EXEC, alu});
    add(6'b000000, f, 1'b0, 4'd7, C_ALUWB);
  endtask

  initial begin
    // lw
    add(6'b100011, 6'd0, 1'b0, 4'd0, C_FETCH);
    add(6'b100011, 6'd0, 1'b0, 4'd1, C_DECODE);
    add(6'b100011, 6'd0, 1'b0, 4'd2, C_MEMADR);
    add(6'b100011, 6'd0, 1'b0, 4'd3, C_MEMRD);
    add(6'b100011, 6'd0, 1'b0, 4'd4, C_MEMWB);
    // R-type: add, sub, and, or, slt, unknown
    add_rtype(6'b100000, 3'b010);
    add_rtype(6'b100010, 3'b110);
    add_rtype(6'b100100, 3'b000);
    add_rtype(6'b100101, 3'b001);
    add_rtype(6'b101010, 3'b111);
    add_rtype(6'b000000, 3'b011);
    // beq taken, then not taken
    add(6'b000100, 6'd0, 1'b1, 4'd0, C_FETCH);
    add(6'b000100, 6'd0, 1'b1, 4'd1, C_DECODE);
    add(6'b000100, 6'd0, 1'b1, 4'd8, C_BEQ_T);
    add(6'b000100, 6'd0, 1'b0, 4'd0, C_FETCH);
    add(6'b000100, 6'd0, 1'b0, 4'd1, C_DECODE);
    add(6'b000100, 6'd0, 1'b0, 4'd8, C_BEQ_F);
    // sw
    add(6'b101011, 6'd0, 1'b0, 4'd0, C_FETCH);
    add(6'b101011, 6'd0, 1'b0, 4'd1, C_DECODE);
    add(6'b101011, 6'd0, 1'b0, 4'd2, C_MEMADR);
    add(6'b101011, 6'd0, 1'b0, 4'd5, C_MEMWR);
    // j
    add(6'b000010, 6'd0, 1'b0, 4'd0, C_FETCH);
    add(6'b000010, 6'd0, 1'b0, 4'd1, C_DECODE);
    add(6'b000010, 6'd0, 1'b0, 4'd11, C_JUMP);
    // unknown op acts as NOP
    add(6'b111111, 6'd0, 1'b0, 4'd0, C_FETCH);
    add(6'b111111, 6'd0, 1'b0, 4'd1, C_DECODE);
    // addi
    add(6'b001000, 6'd0, 1'b0, 4'd0, C_FETCH);
    add(6'b001000, 6'd0, 1'b0, 4'd1, C_DECODE);
    add(6'b001000, 6'd0, 1'b0, 4'd9, C_MEMADR);
    add(6'b001000, 6'd0, 1'b0, 4'd10, C_ADDIWB);
    add(6'b000000, 6'd0, 1'b0, 4'd0, C_FETCH);

    // reset held for 3 cycles
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctl", 32'(ctl), 32'(C_RST));
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      op = vecs[i].op;
      funct = vecs[i].funct;
      zero = vecs[i].zero;
      #1;
      chk($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("row%0d_ctl", i), 32'(ctl), 32'(vecs[i].ctl));
      @(posedge clk);
      @(negedge clk);
    end

    // mid-instruction reset during lw writeback
    op = 6'b100011; funct = 6'd0; zero = 1'b0;
    #1;
    chk("mid_fetch_state", 32'(state), 32'd1);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("mid_memwb_state", 32'(state), 32'd4);
    chk("mid_memwb_regwrite", 32'(regwrite), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_regwrite", 32'(regwrite), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_ctl", 32'(ctl), 32'(C_RST));
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_ctl", 32'(ctl), 32'(C_FETCH));
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("post_rst_decode", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
